// File: rtl/store_align_unit_if.sv
// Store request / data-memory write port bundle for store_align_unit.
// master = execute stage + memory side, slave = the align unit.
interface store_align_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [2:0]        req_type;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_addr, req_data, req_type, mem_gnt,
    input  req_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_type, mem_gnt,
    output req_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err
  );
endinterface

// File: rtl/store_align_unit.sv
// Store lane alignment and byte-enable generation onto a word-addressed req/gnt write port.
// `define MISALIGN_SPLIT_EN splits misaligned SH/SW into two beats; otherwise they are rejected.
module store_align_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  store_align_unit_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
`ifdef MISALIGN_SPLIT_EN
  localparam logic [1:0] BEAT1 = 2'd2;
`endif

  localparam logic [2:0] TYPE_SB = 3'b000;
  localparam logic [2:0] TYPE_SH = 3'b001;
  localparam logic [2:0] TYPE_SW = 3'b010;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic [3:0]        hi_be_q, hi_be_d;
  logic [31:0]       hi_wdata_q, hi_wdata_d;
`endif

  // Lane math on the incoming request
  logic [1:0]  k;
  logic [3:0]  mask;
  logic [31:0] sized;
  logic [3:0]  be_lo;
  logic [31:0] wdata_lo;
  logic        legal;
  logic        misaligned;
  logic        reject;
  logic        accept;
  logic        last_gnt;

  assign k = bus.req_addr[1:0];

  always_comb begin
    mask  = 4'b0000;
    legal = 1'b1;
    case (bus.req_type)
      TYPE_SB: mask = 4'b0001;
      TYPE_SH: mask = 4'b0011;
      TYPE_SW: mask = 4'b1111;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    sized = '0;
    for (int i = 0; i < 4; i++) begin
      sized[8*i +: 8] = mask[i] ? bus.req_data[8*i +: 8] : 8'h00;
    end
  end

  assign be_lo      = mask << k;
  assign wdata_lo   = sized << {k, 3'b000};
  assign misaligned = ((bus.req_type == TYPE_SH) && (k == 2'd3)) ||
                      ((bus.req_type == TYPE_SW) && (k != 2'd0));

`ifdef MISALIGN_SPLIT_EN
  // Upper half of the 8-lane / 64-bit shifted view; shift counts of 4 and 32 yield zero.
  logic [3:0]  be_hi;
  logic [31:0] wdata_hi;
  assign be_hi    = mask >> (3'd4 - {1'b0, k});
  assign wdata_hi = sized >> (6'd32 - {1'b0, k, 3'b000});
  assign reject   = !legal;
`else
  assign reject   = !legal || misaligned;
`endif

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    req_d    = req_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    last_gnt = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    split_d    = split_q;
    hi_be_d    = hi_be_q;
    hi_wdata_d = hi_wdata_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = BEAT0;
            req_d   = 1'b1;
            addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            be_d    = be_lo;
            wdata_d = wdata_lo;
`ifdef MISALIGN_SPLIT_EN
            split_d    = misaligned;
            hi_be_d    = be_hi;
            hi_wdata_d = wdata_hi;
`endif
          end
        end
      end
      BEAT0: begin
        if (bus.mem_gnt) begin
`ifdef MISALIGN_SPLIT_EN
          if (split_q) begin
            // Second beat follows with no gap; address wraps naturally at 2^ADDR_W.
            state_d = BEAT1;
            addr_d  = addr_q + ADDR_W'(4);
            be_d    = hi_be_q;
            wdata_d = hi_wdata_q;
          end else begin
            last_gnt = 1'b1;
          end
`else
          last_gnt = 1'b1;
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      BEAT1: begin
        if (bus.mem_gnt) begin
          last_gnt = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        be_d    = '0;
      end
    endcase

    if (last_gnt) begin
      state_d = IDLE;
      req_d   = 1'b0;
      addr_d  = '0;
      be_d    = '0;
      wdata_d = '0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      split_q    <= 1'b0;
      hi_be_q    <= '0;
      hi_wdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MISALIGN_SPLIT_EN
      split_q    <= split_d;
      hi_be_q    <= hi_be_d;
      hi_wdata_q <= hi_wdata_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Store-side counterpart of the load-data select logic in the core.
- Accepts one store request per handshake from the execute stage (address, register data, store type).
- Shifts the data onto the correct byte lanes, generates the 4-bit byte-enable, and drives a word-addressed req/gnt write port on data memory.
- Sits between the execute stage and the data-memory write port; one store in flight at a time.

Parameters:
ADDR_W, 32, width of req_addr and mem_addr.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  store request valid
req_ready  output  1  unit can accept a request (high only in IDLE)
req_addr  input  ADDR_W  byte address of the store
req_data  input  32  rs2 register value, LSB-justified
req_type  input  3  000=SB, 001=SH, 010=SW; any other code is illegal
mem_req  output  1  memory write request
mem_gnt  input  1  memory accepts the current beat this cycle
mem_addr  output  ADDR_W  word-aligned address (bits [1:0] = 00)
mem_wdata  output  32  lane-aligned write data
mem_be  output  4  byte enables; bit i = byte lane i
done  output  1  one-cycle pulse: store completed
err  output  1  one-cycle pulse: store rejected, no memory write issued

Behaviour:
- Reset (async, immediate, including mid-transaction): state=IDLE, req_ready=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, err=0. An in-flight beat is dropped.
- States: IDLE, BEAT0, BEAT1.
- Accept: req_valid & req_ready at edge N. Address, data and type are registered. mem_req rises in cycle N+1 (registered output); no combinational path from req_* to mem_*.
- Lane math, with k = req_addr[1:0]:
  - mask = 0001 for SB, 0011 for SH, 1111 for SW.
  - sized = req_data with bytes outside mask forced to 0.
  - wide_be = mask << k, 8 bits.
  - wide_data = sized << 8k, 64 bits.
  - Beat0: mem_addr = {addr[ADDR_W-1:2], 00}, mem_be = wide_be[3:0], mem_wdata = wide_data[31:0].
  - Beat1, misaligned only: mem_addr = beat0 addr + 4, wrapping modulo 2^ADDR_W. mem_be = wide_be[7:4], mem_wdata = wide_data[63:32].
  - Disabled lanes are always 0.
- Misaligned: SH with k=3, or SW with k≠0. SB is never misaligned.
- IDLE -> BEAT0 on accept with legal type and a non-rejected alignment.
- BEAT0: hold mem_req=1 with mem_addr/be/wdata stable until mem_gnt.
  - On gnt, if not split: go to IDLE, done=1 next cycle.
  - On gnt, if split: go to BEAT1, mem_req stays high with beat1 values the next cycle. No gap cycle.
- BEAT1: hold until mem_gnt; then go to IDLE, done=1 next cycle.
- After the final gnt, mem_req=0 and mem_be=0 in the next cycle. req_ready returns to 1 in that same cycle, so back-to-back accepts are possible at one store per 2 cycles with zero-wait gnt.
- Illegal req_type: accepted, err=1 in cycle N+1, no mem_req, stays in IDLE.
- mem_gnt while mem_req=0 is ignored.
- req_valid while not ready is ignored; the requester must hold it.
- done and err are never asserted together.

Optional Feature:
MISALIGN_SPLIT_EN
- Defined: misaligned SH/SW is split into BEAT0 and BEAT1 as above; done after the second gnt.
- Undefined: a misaligned SH/SW is accepted, err pulses in cycle N+1, no mem_req is issued, and the state stays IDLE. BEAT1 logic is not synthesized.

Test Plan:
- SB, addr 0x102, data 0x12345678, gnt tied high -> one beat: mem_addr 0x100, be 0100, wdata 0x00780000; done pulses 2 cycles after accept.
- SH, addr 0x200, data 0xAABB5678, gnt delayed 3 cycles -> mem_req held 4 cycles with be 0011, wdata 0x00005678 stable throughout; single done.
- SW, addr 0x301 with MISALIGN_SPLIT_EN -> beat0 addr 0x300, be 1110, wdata 0x34567800; beat1 addr 0x304, be 0001, wdata 0x00000012; done after second gnt.
  - Same stimulus without the macro -> err pulse, mem_req never asserted.
- SH, addr 0xFFFFFFFF, data 0x0000BEEF, with macro -> beat0 addr 0xFFFFFFFC, be 1000, wdata 0xEF000000; beat1 addr 0x00000000, be 0001, wdata 0x000000BE.
- req_type 011 -> err pulse, no write. Then rst_n low during BEAT0 of an SW with gnt low -> mem_req drops immediately, all outputs 0, req_ready 1.
- Back-to-back SB to 0x0, 0x1, 0x2, 0x3 with req_valid held, data 0x12345678 -> be 0001, 0010, 0100, 1000 with wdata 0x00000078, 0x00007800, 0x00780000, 0x78000000; four done pulses, one store per 2 cycles.
